// File: rtl/tone_pkg.sv
// Shared types for the buzzer arbiter: note codes, arbiter states and grant encodings.
package tone_pkg;

   localparam int NOTE_W = 6;
   localparam logic [NOTE_W-1:0] REST_NOTE = 6'd63;

   typedef enum logic [2:0] {
      IDLE,
      ALARM,
      SNOOZE,
      BEEP,
      CHIME_ON,
      CHIME_OFF
   } tone_state_t;

   localparam logic [1:0] GNT_NONE  = 2'd0;
   localparam logic [1:0] GNT_ALARM = 2'd1;
   localparam logic [1:0] GNT_BEEP  = 2'd2;
   localparam logic [1:0] GNT_CHIME = 2'd3;

   function automatic logic [1:0] grant_of(tone_state_t s);
      case (s)
         ALARM:              return GNT_ALARM;
         BEEP:               return GNT_BEEP;
         CHIME_ON, CHIME_OFF: return GNT_CHIME;
         default:            return GNT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/tone_ms_timer.sv
// Millisecond down-counter shared by all arbiter states; done fires on the tick that
// reaches zero (or on the first tick after loading zero).
module tone_ms_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             tick,
   output logic             done
);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= value;
      end else if (tick && cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = tick && (cnt <= CNT_W'(1));

endmodule

// File: rtl/tone_arbiter.sv
// Shares the buzzer between the alarm song, hourly chime and key beeps.
// The chime path is built only when TONE_ARB_CHIME_EN is defined.
module tone_arbiter
   import tone_pkg::*;
#(
   parameter int                CNT_W        = 20,
   parameter int                ALARM_MAX_MS = 60000,
   parameter int                SNOOZE_MS    = 300000,
   parameter int                MAX_SNOOZE   = 3,
   parameter int                BEEP_MS      = 80,
   parameter logic [NOTE_W-1:0] BEEP_NOTE    = 6'd27,
   parameter int                CHIME_COUNT  = 2,
   parameter int                CHIME_ON_MS  = 200,
   parameter int                CHIME_OFF_MS = 150,
   parameter logic [NOTE_W-1:0] CHIME_NOTE   = 6'd22
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick_ms,
   input  logic              alarm_req,
   input  logic [NOTE_W-1:0] alarm_note,
   input  logic              snooze,
   input  logic              stop,
   input  logic              key_beep,
   input  logic              chime_req,
   output logic [NOTE_W-1:0] note,
   output logic              song_run,
   output logic [1:0]        grant,
   output logic              alarm_timeout
);

   localparam int SNZ_W = $clog2(MAX_SNOOZE + 1);
   localparam logic [CNT_W-1:0] T_ALARM  = CNT_W'(ALARM_MAX_MS);
   localparam logic [CNT_W-1:0] T_SNOOZE = CNT_W'(SNOOZE_MS);
   localparam logic [CNT_W-1:0] T_BEEP   = CNT_W'(BEEP_MS);

   tone_state_t       state, state_n;
   logic              areq_q;
   logic              alarm_edge;
   logic [SNZ_W-1:0]  snz_cnt, snz_n;
   logic              beep_pend, beep_pend_n;
   logic              timeout_n;
   logic              ld;
   logic [CNT_W-1:0]  ld_val;
   logic              tmr_done;
   logic [NOTE_W-1:0] note_r;

   function automatic logic [NOTE_W-1:0] note_of(tone_state_t s);
      case (s)
         BEEP:     return BEEP_NOTE;
         CHIME_ON: return CHIME_NOTE;
         default:  return REST_NOTE;
      endcase
   endfunction

   tone_ms_timer #(.CNT_W(CNT_W)) u_timer (
      .clk   (clk),
      .rst   (rst),
      .load  (ld),
      .value (ld_val),
      .tick  (tick_ms),
      .done  (tmr_done)
   );

   assign alarm_edge = alarm_req & ~areq_q;

`ifdef TONE_ARB_CHIME_EN
   localparam int IDX_W = $clog2(CHIME_COUNT + 1);
   localparam logic [CNT_W-1:0] T_CON  = CNT_W'(CHIME_ON_MS);
   localparam logic [CNT_W-1:0] T_COFF = CNT_W'(CHIME_OFF_MS);

   logic [IDX_W-1:0] chime_idx, idx_n;
   logic             chime_pend, chime_pend_n;

   always_ff @(posedge clk) begin
      if (rst) begin
         chime_idx  <= '0;
         chime_pend <= 1'b0;
      end else begin
         chime_idx  <= idx_n;
         chime_pend <= chime_pend_n;
      end
   end
`else
   logic unused_chime;
   assign unused_chime = ^{chime_req, CNT_W'(CHIME_ON_MS), CNT_W'(CHIME_OFF_MS), 8'(CHIME_COUNT)};
`endif

   always_comb begin
      state_n     = state;
      ld          = 1'b0;
      ld_val      = '0;
      snz_n       = snz_cnt;
      beep_pend_n = beep_pend;
      timeout_n   = 1'b0;
`ifdef TONE_ARB_CHIME_EN
      chime_pend_n = chime_pend;
      idx_n        = chime_idx;
`endif
      // A fresh alarm pre-empts everything except an in-progress snooze.
      if (alarm_edge && state != SNOOZE) begin
         state_n     = ALARM;
         ld          = 1'b1;
         ld_val      = T_ALARM;
         snz_n       = '0;
         beep_pend_n = 1'b0;
`ifdef TONE_ARB_CHIME_EN
         chime_pend_n = 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (beep_pend) begin
                  beep_pend_n = 1'b0;
                  state_n     = BEEP;
                  ld          = 1'b1;
                  ld_val      = T_BEEP;
               end
`ifdef TONE_ARB_CHIME_EN
               else if (chime_pend) begin
                  chime_pend_n = 1'b0;
                  state_n      = CHIME_ON;
                  idx_n        = '0;
                  ld           = 1'b1;
                  ld_val       = T_CON;
               end
`endif
               else if (key_beep) begin
                  state_n = BEEP;
                  ld      = 1'b1;
                  ld_val  = T_BEEP;
`ifdef TONE_ARB_CHIME_EN
                  chime_pend_n = chime_req;
`endif
               end
`ifdef TONE_ARB_CHIME_EN
               else if (chime_req) begin
                  state_n = CHIME_ON;
                  idx_n   = '0;
                  ld      = 1'b1;
                  ld_val  = T_CON;
               end
`endif
            end
            ALARM: begin
               if (stop) begin
                  state_n = IDLE;
               end else if (snooze) begin
                  if (snz_cnt < SNZ_W'(MAX_SNOOZE)) begin
                     state_n = SNOOZE;
                     snz_n   = snz_cnt + 1'b1;
                     ld      = 1'b1;
                     ld_val  = T_SNOOZE;
                  end else begin
                     state_n = IDLE;
                  end
               end else if (tmr_done) begin
                  state_n   = IDLE;
                  timeout_n = 1'b1;
               end
            end
            SNOOZE: begin
               if (stop) begin
                  state_n = IDLE;
               end else if (tmr_done) begin
                  state_n = ALARM;
                  ld      = 1'b1;
                  ld_val  = T_ALARM;
               end
            end
            BEEP: begin
`ifdef TONE_ARB_CHIME_EN
               if (chime_req) chime_pend_n = 1'b1;
`endif
               if (key_beep) begin
                  ld     = 1'b1;
                  ld_val = T_BEEP;
               end else if (tmr_done) begin
                  state_n = IDLE;
               end
            end
`ifdef TONE_ARB_CHIME_EN
            CHIME_ON: begin
               if (key_beep) beep_pend_n = 1'b1;
               if (tmr_done) begin
                  state_n = CHIME_OFF;
                  ld      = 1'b1;
                  ld_val  = T_COFF;
               end
            end
            CHIME_OFF: begin
               if (key_beep) beep_pend_n = 1'b1;
               if (tmr_done) begin
                  idx_n = chime_idx + 1'b1;
                  if (chime_idx + 1'b1 == IDX_W'(CHIME_COUNT)) begin
                     state_n = IDLE;
                  end else begin
                     state_n = CHIME_ON;
                     ld      = 1'b1;
                     ld_val  = T_CON;
                  end
               end
            end
`endif
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         areq_q        <= 1'b0;
         snz_cnt       <= '0;
         beep_pend     <= 1'b0;
         note_r        <= REST_NOTE;
         song_run      <= 1'b0;
         grant         <= GNT_NONE;
         alarm_timeout <= 1'b0;
      end else begin
         state         <= state_n;
         areq_q        <= alarm_req;
         snz_cnt       <= snz_n;
         beep_pend     <= beep_pend_n;
         note_r        <= note_of(state_n);
         song_run      <= (state_n == ALARM);
         grant         <= grant_of(state_n);
         alarm_timeout <= timeout_n;
      end
   end

   // The song note must follow the music player without an extra cycle of delay.
   assign note = (state == ALARM) ? alarm_note : note_r;

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_tone_arbiter;

   localparam int AMAX = 100, SNZ = 20, MAXS = 2, BEEPN = 5;
   localparam int CC = 2, CON = 4, COFF = 3;
`ifdef TONE_ARB_CHIME_EN
   localparam bit CH_EN = 1'b1;
`else
   localparam bit CH_EN = 1'b0;
`endif
   localparam int M_IDLE = 0, M_ALARM = 1, M_SNOOZE = 2, M_BEEP = 3, M_CHIME = 4;

   logic       clk = 1'b0;
   logic       rst, tick_ms, alarm_req, snooze, stop, key_beep, chime_req;
   logic [5:0] alarm_note, note;
   logic       song_run, alarm_timeout;
   logic [1:0] grant;

   int total = 0, bad = 0, cyc = 0;

   int m_mode, m_rem, m_snz, m_ph;
   bit m_bp, m_cp, m_prev, m_to;

   tone_arbiter #(
      .CNT_W(20), .ALARM_MAX_MS(AMAX), .SNOOZE_MS(SNZ), .MAX_SNOOZE(MAXS),
      .BEEP_MS(BEEPN), .BEEP_NOTE(6'd27), .CHIME_COUNT(CC), .CHIME_ON_MS(CON),
      .CHIME_OFF_MS(COFF), .CHIME_NOTE(6'd22)
   ) dut (
      .clk(clk), .rst(rst), .tick_ms(tick_ms), .alarm_req(alarm_req),
      .alarm_note(alarm_note), .snooze(snooze), .stop(stop), .key_beep(key_beep),
      .chime_req(chime_req), .note(note), .song_run(song_run), .grant(grant),
      .alarm_timeout(alarm_timeout)
   );

   always #5 clk = ~clk;

   // Behavioural model: one activity at a time, remaining milliseconds, chime phase.
   task automatic model_update();
      bit edg, expd;
      if (rst) begin
         m_mode = M_IDLE; m_rem = 0; m_snz = 0; m_ph = 0;
         m_bp = 0; m_cp = 0; m_prev = 0; m_to = 0;
         return;
      end
      edg    = alarm_req && !m_prev;
      m_prev = alarm_req;
      expd   = tick_ms && (m_rem <= 1);
      if (tick_ms && m_rem > 0) m_rem--;
      m_to = 0;
      if (edg && m_mode != M_SNOOZE) begin
         m_mode = M_ALARM; m_rem = AMAX; m_snz = 0; m_bp = 0; m_cp = 0;
      end else begin
         case (m_mode)
            M_IDLE: begin
               if (m_bp) begin m_bp = 0; m_mode = M_BEEP; m_rem = BEEPN; end
               else if (m_cp) begin m_cp = 0; m_mode = M_CHIME; m_ph = 0; m_rem = CON; end
               else if (key_beep) begin
                  m_mode = M_BEEP; m_rem = BEEPN;
                  if (CH_EN && chime_req) m_cp = 1;
               end else if (CH_EN && chime_req) begin
                  m_mode = M_CHIME; m_ph = 0; m_rem = CON;
               end
            end
            M_ALARM: begin
               if (stop) m_mode = M_IDLE;
               else if (snooze) begin
                  if (m_snz < MAXS) begin m_snz++; m_mode = M_SNOOZE; m_rem = SNZ; end
                  else m_mode = M_IDLE;
               end else if (expd) begin m_mode = M_IDLE; m_to = 1; end
            end
            M_SNOOZE: begin
               if (stop) m_mode = M_IDLE;
               else if (expd) begin m_mode = M_ALARM; m_rem = AMAX; end
            end
            M_BEEP: begin
               if (CH_EN && chime_req) m_cp = 1;
               if (key_beep) m_rem = BEEPN;
               else if (expd) m_mode = M_IDLE;
            end
            M_CHIME: begin
               if (key_beep) m_bp = 1;
               if (expd) begin
                  m_ph++;
                  if (m_ph == 2 * CC) m_mode = M_IDLE;
                  else m_rem = (m_ph % 2 == 0) ? CON : COFF;
               end
            end
            default: ;
         endcase
      end
   endtask

   function automatic logic [9:0] exp_vec();
      logic [5:0] n;
      logic [1:0] g;
      n = 6'd63;
      g = 2'd0;
      case (m_mode)
         M_ALARM: begin n = alarm_note; g = 2'd1; end
         M_BEEP:  begin n = 6'd27; g = 2'd2; end
         M_CHIME: begin g = 2'd3; if (m_ph % 2 == 0) n = 6'd22; end
         default: ;
      endcase
      return {n, (m_mode == M_ALARM), g, m_to};
   endfunction

   task automatic step();
      @(posedge clk);
      model_update();
      #1;
      snooze = 0; stop = 0; key_beep = 0; chime_req = 0;
      cyc++;
      tick_ms = (cyc % 4 == 3);
   endtask

   task automatic wait_ticks(input int n);
      int k = 0;
      while (k < n) begin
         if (tick_ms) k++;
         step();
      end
   endtask

   task automatic start_alarm(input logic [5:0] nt);
      alarm_req = 0; alarm_note = nt;
      step();
      alarm_req = 1;
      step();
      alarm_req = 0;
   endtask

   task automatic test_reset();
      rst = 1; alarm_req = 1;
      step(); step();
      total++; if (note !== 6'd63) begin bad++; $display("FAIL rst_note got=%0d want=63", note); end
      total++; if (song_run !== 1'b0) begin bad++; $display("FAIL rst_song got=%b want=0", song_run); end
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL rst_grant got=%0d want=0", grant); end
      total++; if (alarm_timeout !== 1'b0) begin bad++; $display("FAIL rst_timeout got=%b want=0", alarm_timeout); end
      alarm_req = 0; rst = 0;
      step();
   endtask

   task automatic test_alarm_timeout();
      int ticks = 0;
      bit seen = 0, t;
      alarm_note = 6'd19; alarm_req = 1;
      step();
      total++; if ({song_run, note, grant} !== {1'b1, 6'd19, 2'd1}) begin
         bad++; $display("FAIL alarm_start got=%b/%0d/%0d want=1/19/1", song_run, note, grant);
      end
      for (int i = 0; i < 700 && !seen; i++) begin
         t = tick_ms;
         step();
         if (t) ticks++;
         if (alarm_timeout) seen = 1;
      end
      total++; if (!seen) begin bad++; $display("FAIL alarm_timeout_wait got=none want=pulse"); end
      total++; if (ticks !== AMAX) begin bad++; $display("FAIL alarm_duration got=%0d want=%0d", ticks, AMAX); end
      total++; if ({note, song_run} !== {6'd63, 1'b0}) begin
         bad++; $display("FAIL alarm_end got=%0d/%b want=63/0", note, song_run);
      end
      step();
      total++; if (alarm_timeout !== 1'b0) begin bad++; $display("FAIL timeout_width got=%b want=0", alarm_timeout); end
      alarm_req = 0;
      step();
   endtask

   task automatic test_snooze();
      int cnt;
      bit bad_seen = 0;
      start_alarm(6'd33);
      wait_ticks(10);
      for (int s = 0; s < 2; s++) begin
         snooze = 1;
         step();
         total++; if ({note, song_run, grant} !== {6'd63, 1'b0, 2'd0}) begin
            bad++; $display("FAIL snooze_enter%0d got=%0d/%b/%0d want=63/0/0", s, note, song_run, grant);
         end
         cnt = 0;
         for (int i = 0; i < 200 && grant !== 2'd1; i++) begin
            if (tick_ms) cnt++;
            step();
         end
         total++; if (cnt !== SNZ) begin bad++; $display("FAIL snooze_len%0d got=%0d want=%0d", s, cnt, SNZ); end
         total++; if ({song_run, note} !== {1'b1, 6'd33}) begin
            bad++; $display("FAIL snooze_resume%0d got=%b/%0d want=1/33", s, song_run, note);
         end
         wait_ticks(2);
      end
      snooze = 1;
      step();
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL snooze_limit got=%0d want=0", grant); end
      for (int i = 0; i < 500; i++) begin
         step();
         if (alarm_timeout || grant !== 2'd0) bad_seen = 1;
      end
      total++; if (bad_seen) begin bad++; $display("FAIL snooze_limit_quiet got=activity want=idle"); end
   endtask

   task automatic test_stop_snooze();
      bit bad_seen = 0;
      start_alarm(6'd5);
      wait_ticks(3);
      snooze = 1; stop = 1;
      step();
      total++; if ({grant, note, song_run} !== {2'd0, 6'd63, 1'b0}) begin
         bad++; $display("FAIL stop_wins got=%0d/%0d/%b want=0/63/0", grant, note, song_run);
      end
      for (int i = 0; i < 120; i++) begin
         step();
         if (grant !== 2'd0) bad_seen = 1;
      end
      total++; if (bad_seen) begin bad++; $display("FAIL stop_no_resume got=active want=idle"); end
   endtask

   task automatic test_chime();
`ifdef TONE_ARB_CHIME_EN
      int len [4] = '{CON, COFF, CON, COFF};
      logic [5:0] nts [4] = '{6'd22, 6'd63, 6'd22, 6'd63};
      int cnt;
      bit kb_sent = 0;
      logic [5:0] cur;
      chime_req = 1;
      step();
      total++; if ({grant, note} !== {2'd3, 6'd22}) begin
         bad++; $display("FAIL chime_start got=%0d/%0d want=3/22", grant, note);
      end
      for (int p = 0; p < 4; p++) begin
         cnt = 0;
         cur = note;
         for (int i = 0; i < 100 && note === cur && grant === 2'd3; i++) begin
            if (p == 0 && cnt == 2 && !kb_sent) begin key_beep = 1; kb_sent = 1; end
            if (tick_ms) cnt++;
            step();
         end
         total++; if ({cur, 8'(cnt)} !== {nts[p], 8'(len[p])}) begin
            bad++; $display("FAIL chime_phase%0d got=%0d/%0d want=%0d/%0d", p, cur, cnt, nts[p], len[p]);
         end
      end
      for (int i = 0; i < 4 && grant !== 2'd2; i++) step();
      total++; if ({grant, note} !== {2'd2, 6'd27}) begin
         bad++; $display("FAIL chime_then_beep got=%0d/%0d want=2/27", grant, note);
      end
      cnt = 0;
      for (int i = 0; i < 100 && grant === 2'd2; i++) begin
         if (tick_ms) cnt++;
         step();
      end
      total++; if (cnt !== BEEPN) begin bad++; $display("FAIL pend_beep_len got=%0d want=%0d", cnt, BEEPN); end
`else
      bit bad_seen = 0;
      chime_req = 1;
      step();
      total++; if ({grant, note} !== {2'd0, 6'd63}) begin
         bad++; $display("FAIL chime_ignored got=%0d/%0d want=0/63", grant, note);
      end
      for (int i = 0; i < 40; i++) begin
         step();
         if (grant === 2'd3) bad_seen = 1;
      end
      total++; if (bad_seen) begin bad++; $display("FAIL chime_never got=grant3 want=none"); end
`endif
   endtask

   task automatic test_back_to_back();
      int cnt = 0;
      bit restarted = 0, bad_seen = 0;
      key_beep = 1;
      step();
      total++; if ({grant, note} !== {2'd2, 6'd27}) begin
         bad++; $display("FAIL beep_start got=%0d/%0d want=2/27", grant, note);
      end
      for (int i = 0; i < 200 && grant === 2'd2; i++) begin
         if (cnt == 3 && !restarted && !tick_ms) begin key_beep = 1; restarted = 1; end
         if (tick_ms) cnt++;
         step();
      end
      total++; if (cnt !== 3 + BEEPN) begin bad++; $display("FAIL beep_restart_len got=%0d want=%0d", cnt, 3 + BEEPN); end
      start_alarm(6'd40);
      wait_ticks(2);
      chime_req = 1;
      step();
      total++; if (grant !== 2'd1) begin bad++; $display("FAIL chime_in_alarm got=%0d want=1", grant); end
      wait_ticks(2);
      stop = 1;
      step();
      for (int i = 0; i < 40; i++) begin
         if (grant !== 2'd0) bad_seen = 1;
         step();
      end
      total++; if (bad_seen) begin bad++; $display("FAIL chime_dropped got=active want=idle"); end
   endtask

   task automatic test_reset_mid();
      bit bad_seen = 0;
`ifdef TONE_ARB_CHIME_EN
      chime_req = 1;
      step();
      wait_ticks(1);
      key_beep = 1;
      step();
      total++; if (grant !== 2'd3) begin bad++; $display("FAIL rst_mid_pre got=%0d want=3", grant); end
`else
      key_beep = 1;
      step();
      wait_ticks(1);
      total++; if (grant !== 2'd2) begin bad++; $display("FAIL rst_mid_pre got=%0d want=2", grant); end
`endif
      rst = 1;
      step();
      total++; if ({note, grant} !== {6'd63, 2'd0}) begin
         bad++; $display("FAIL rst_mid got=%0d/%0d want=63/0", note, grant);
      end
      rst = 0;
      for (int i = 0; i < 60; i++) begin
         step();
         if (grant !== 2'd0) bad_seen = 1;
      end
      total++; if (bad_seen) begin bad++; $display("FAIL rst_mid_no_pend got=active want=idle"); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 299) == 0) alarm_req = ~alarm_req;
         alarm_note = 6'($urandom_range(0, 63));
         snooze    = ($urandom_range(0, 149) == 0);
         stop      = ($urandom_range(0, 249) == 0);
         key_beep  = ($urandom_range(0, 39) == 0);
         chime_req = ($urandom_range(0, 59) == 0);
         rst       = ($urandom_range(0, 1499) == 0);
         step();
         total++;
         if ({note, song_run, grant, alarm_timeout} !== exp_vec()) begin
            bad++;
            $display("FAIL random cyc=%0d got=%b/%0d/%b/%0d/%b want=%b", cyc, rst, note, song_run,
                     grant, alarm_timeout, exp_vec());
         end
      end
      rst = 0;
   endtask

   initial begin
      rst = 1; tick_ms = 0; alarm_req = 0; alarm_note = 0;
      snooze = 0; stop = 0; key_beep = 0; chime_req = 0;
      test_reset();
      test_alarm_timeout();
      test_snooze();
      test_stop_snooze();
      test_chime();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
